execute_alu_stage: RTL and testbench
====================================

// Module: execute_alu_stage
// PURPOSE
//   Y86-64 execute stage. Consumes decoded fields and register values, selects
//   ALU operands, computes valE (add/sub/and/xor), keeps the ZF/SF/OF condition
//   code register and evaluates Cnd. Registered output slot with valid/ready
//   handshake feeds the memory stage. Sits between decode and memory.
// PARAMETERS
//   DATA_W     64      datapath width (fixed at 64 for Y86-64)
//   STACK_STEP 8       stack adjust for call/push (-) and ret/pop (+)
//   CC_RESET   3'b100  reset value of {ZF,SF,OF}
// PORTS
//   clk        in   1       clock, rising edge
//   rst        in   1       asynchronous, active-high reset
//   in_valid   in   1       decode offers an instruction
//   in_ready   out  1       stage can accept; = !out_valid | out_ready
//   icode      in   4       Y86 instruction code
//   ifun       in   4       Y86 function code
//   valA       in   DATA_W  register A value
//   valB       in   DATA_W  register B value
//   valC       in   DATA_W  immediate/displacement
//   out_valid  out  1       result slot holds a valid instruction
//   out_ready  in   1       memory stage accepts the result
//   valE       out  DATA_W  ALU result
//   cnd        out  1       condition result for cmovXX/jXX
//   cc         out  3       current {ZF,SF,OF}
//   bad_instr  out  1       registered: accepted icode > 4'hB
// BEHAVIOUR
// - Reset (async, any cycle, including mid-transfer): out_valid=0, valE=0,
//   cnd=0, bad_instr=0, cc=CC_RESET, in-flight result dropped.
// - Accept = in_valid & in_ready; the result registers 1 cycle later.
// - Output holds stable while out_valid & !out_ready.
// - Simultaneous pop and accept is allowed (full throughput, 1 instr/cycle).
// - aluA:
//   - valA for icode 2 and 6.
//   - valC for icode 3, 4 and 5.
//   - -STACK_STEP for icode 8 and A; +STACK_STEP for icode 9 and B.
//   - 0 otherwise.
// - aluB: valB for icode 4, 5, 6, 8, 9, A and B; 0 otherwise.
// - ALU function: ifun when icode=6, else ADD. ifun 0 is add (B+A),
//   1 is sub (B-A), 2 is and, 3 is xor. OPq with ifun>3 gives valE=0,
//   leaves cc unchanged, sets bad_instr=1.
// - Arithmetic is modulo 2^64, carry-out discarded.
// - OF rules:
//   - add: sign(A)==sign(B) and sign(E)!=sign(A).
//   - sub: sign(A)!=sign(B) and sign(E)!=sign(B).
//   - and/xor: OF=0.
// - CC: updates only on an accepted OPq with ifun<=3, on that same edge:
//   ZF=(E==0), SF=E[63], OF as above.
// - Cnd uses the CC value before any update on the same edge.
//   - Applies to icode 2 and 7 only; 0 for every other icode.
//   - ifun 0 is always, 1 is le ((SF^OF)|ZF), 2 is l (SF^OF), 3 is e (ZF),
//     4 is ne (!ZF), 5 is ge (!(SF^OF)), 6 is g (!(SF^OF)&!ZF).
//   - ifun >6 gives 0.
// - icode > 4'hB: valE=0, cnd=0, bad_instr=1, cc unchanged, still passed on
//   with out_valid=1.
// CONFIGURATION
//   EXECUTE_CARRY_FLAG_EN defined:
//   - CF is added; cc widens to 4 bits {ZF,SF,OF,CF}, CC_RESET gets an
//     appended 0.
//   - add: CF = carry-out. sub: CF = borrow (B<A unsigned). and/xor: CF=0.
//   - Cnd ifun 7 is "b" (CF).
//   Undefined: cc is 3 bits, no CF, ifun 7 gives Cnd=0.
// TESTING
// - Reset, then idle: out_valid=0, cc=3'b100, valE=0, in_ready=1.
// - OPq add with valA=5, valB=-5: valE=0, cc={1,0,0}.
//   Next cycle cmovle (icode 2, ifun 1): cnd=1, valE=valA.
// - OPq sub with valA=1, valB=64'h8000_0000_0000_0000: valE=64'h7FFF_FFFF_FFFF_FFFF,
//   cc={0,0,1}. Then jl (ifun 2): cnd=1.
// - pushq with valB=64'h100: valE=64'hF8. popq with valB=64'hF8: valE=64'h100.
//   cc unchanged.
// - Backpressure: hold out_ready=0 for 3 cycles with in_valid=1. Output is
//   stable and in_ready=0. out_ready=1 then pops, accepts and completes
//   back-to-back with no loss.
// - Assert rst while out_valid=1 with a pending OPq: out_valid=0 at once,
//   cc=3'b100. icode=4'hC gives bad_instr=1, valE=0.

Source files
------------

// File: rtl/execute_alu_stage.sv
// Y86-64 execute stage: operand select, ALU, condition codes, Cnd, registered output slot.
// Optional carry flag (4-bit cc, Cnd "b") enabled by defining EXECUTE_CARRY_FLAG_EN.
module execute_alu_stage #(
  parameter int         DATA_W     = 64,
  parameter int         STACK_STEP = 8,
  parameter logic [2:0] CC_RESET   = 3'b100
`ifdef EXECUTE_CARRY_FLAG_EN
  , localparam int      CC_W       = 4
`else
  , localparam int      CC_W       = 3
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [DATA_W-1:0] valA,
  input  logic [DATA_W-1:0] valB,
  input  logic [DATA_W-1:0] valC,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] valE,
  output logic              cnd,
  output logic [CC_W-1:0]   cc,
  output logic              bad_instr
);
  localparam int MSB = DATA_W - 1;
  localparam logic [DATA_W-1:0] STEP = DATA_W'(STACK_STEP);

  localparam logic [3:0] I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3, I_RMMOVQ = 4'h4,
                         I_MRMOVQ = 4'h5, I_OPQ    = 4'h6, I_JXX    = 4'h7,
                         I_CALL   = 4'h8, I_RET    = 4'h9, I_PUSHQ  = 4'hA,
                         I_POPQ   = 4'hB;

`ifdef EXECUTE_CARRY_FLAG_EN
  localparam logic [CC_W-1:0] CC_RST = {CC_RESET, 1'b0};
`else
  localparam logic [CC_W-1:0] CC_RST = CC_RESET;
`endif

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR} alu_fn_e;

  typedef struct packed {
    logic [DATA_W-1:0] val_e;
    logic              cnd;
    logic              bad;
  } ex_res_t;

  logic              accept, op_bad, cc_we, cond;
  alu_fn_e           alu_fn;
  logic [DATA_W-1:0] alu_a, alu_b, alu_e;
  logic              alu_of;
  logic              zf_q, sf_q, of_q;
  logic [CC_W-1:0]   cc_q, cc_d;
  ex_res_t           res_d, res_q;
`ifdef EXECUTE_CARRY_FLAG_EN
  logic              alu_cf, cf_q;
`endif

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    alu_a = '0;
    case (icode)
      I_RRMOVQ, I_OPQ:                 alu_a = valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:    alu_a = valC;
      I_CALL, I_PUSHQ:                 alu_a = '0 - STEP;
      I_RET, I_POPQ:                   alu_a = STEP;
      default: ;
    endcase
  end

  always_comb begin
    alu_b = '0;
    case (icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = valB;
      default: ;
    endcase
  end

  assign alu_fn = (icode == I_OPQ) ? alu_fn_e'(ifun[1:0]) : ALU_ADD;
  // OPq with an undefined function is treated like an illegal icode, not as add.
  assign op_bad = (icode > I_POPQ) || ((icode == I_OPQ) && (ifun[3:2] != 2'b00));

  always_comb begin
    alu_e  = '0;
    alu_of = 1'b0;
`ifdef EXECUTE_CARRY_FLAG_EN
    alu_cf = 1'b0;
`endif
    case (alu_fn)
      ALU_ADD: begin
`ifdef EXECUTE_CARRY_FLAG_EN
        {alu_cf, alu_e} = {1'b0, alu_b} + {1'b0, alu_a};
`else
        alu_e = alu_b + alu_a;
`endif
        alu_of = (alu_a[MSB] == alu_b[MSB]) && (alu_e[MSB] != alu_a[MSB]);
      end
      ALU_SUB: begin
`ifdef EXECUTE_CARRY_FLAG_EN
        {alu_cf, alu_e} = {1'b0, alu_b} - {1'b0, alu_a};
`else
        alu_e = alu_b - alu_a;
`endif
        alu_of = (alu_a[MSB] != alu_b[MSB]) && (alu_e[MSB] != alu_b[MSB]);
      end
      ALU_AND: alu_e = alu_b & alu_a;
      ALU_XOR: alu_e = alu_b ^ alu_a;
      default: ;
    endcase
  end

  assign zf_q = cc_q[CC_W-1];
  assign sf_q = cc_q[CC_W-2];
  assign of_q = cc_q[CC_W-3];
`ifdef EXECUTE_CARRY_FLAG_EN
  assign cf_q = cc_q[0];
  assign cc_d = {alu_e == '0, alu_e[MSB], alu_of, alu_cf};
`else
  assign cc_d = {alu_e == '0, alu_e[MSB], alu_of};
`endif

  // Cnd reads the registered flags, so an OPq landing on the same edge does not affect it.
  always_comb begin
    cond = 1'b0;
    case (ifun)
      4'h0: cond = 1'b1;
      4'h1: cond = (sf_q ^ of_q) | zf_q;
      4'h2: cond = sf_q ^ of_q;
      4'h3: cond = zf_q;
      4'h4: cond = !zf_q;
      4'h5: cond = !(sf_q ^ of_q);
      4'h6: cond = !(sf_q ^ of_q) && !zf_q;
`ifdef EXECUTE_CARRY_FLAG_EN
      4'h7: cond = cf_q;
`endif
      default: ;
    endcase
  end

  assign cc_we       = accept && (icode == I_OPQ) && !op_bad;
  assign res_d.val_e = op_bad ? '0 : alu_e;
  assign res_d.cnd   = ((icode == I_RRMOVQ) || (icode == I_JXX)) && cond;
  assign res_d.bad   = op_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      res_q     <= '0;
      cc_q      <= CC_RST;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        res_q     <= res_d;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (cc_we) cc_q <= cc_d;
    end
  end

  assign valE      = res_q.val_e;
  assign cnd       = res_q.cnd;
  assign bad_instr = res_q.bad;
  assign cc        = cc_q;
endmodule

// File: tb/tb_execute_alu_stage.sv
// Scoreboard bench for execute_alu_stage (default build, 3-bit cc).
module tb_execute_alu_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  icode, ifun;
  logic [63:0] valA, valB, valC, valE;
  logic        cnd, bad_instr;
  logic [2:0]  cc;

  execute_alu_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .out_valid(out_valid), .out_ready(out_ready), .valE(valE), .cnd(cnd),
    .cc(cc), .bad_instr(bad_instr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] vale;
    logic        cnd;
    logic        bad;
  } exp_t;

  exp_t        exp_q[$];
  int          n_total = 0, n_bad = 0;
  logic [2:0]  m_cc;
  logic [63:0] last_vale;
  logic        last_cnd, last_bad;

  // Reference model: expected result for one accepted instruction, flags tracked in m_cc.
  task automatic push_model(input logic [3:0] ic, input logic [3:0] fn,
                            input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    exp_t        e;
    logic        zf, sf, of;
    logic [64:0] wide;
    zf = m_cc[2]; sf = m_cc[1]; of = m_cc[0];
    e = '0;
    wide = '0;
    case (ic)
      4'h2: e.vale = a;
      4'h3: e.vale = c;
      4'h4, 4'h5: e.vale = b + c;
      4'h6: begin
        case (fn)
          4'h0: begin e.vale = b + a; wide = {b[63], b} + {a[63], a}; end
          4'h1: begin e.vale = b - a; wide = {b[63], b} - {a[63], a}; end
          4'h2: begin e.vale = b & a; wide = {e.vale[63], e.vale}; end
          4'h3: begin e.vale = b ^ a; wide = {e.vale[63], e.vale}; end
          default: e.bad = 1'b1;
        endcase
        if (!e.bad) m_cc = {e.vale == 64'd0, e.vale[63], wide != {e.vale[63], e.vale}};
      end
      4'h8, 4'hA: e.vale = b - 64'd8;
      4'h9, 4'hB: e.vale = b + 64'd8;
      4'hC, 4'hD, 4'hE, 4'hF: e.bad = 1'b1;
      default: e.vale = 64'd0;
    endcase
    if (ic == 4'h2 || ic == 4'h7) begin
      case (fn)
        4'h0: e.cnd = 1'b1;
        4'h1: e.cnd = (sf ^ of) | zf;
        4'h2: e.cnd = sf ^ of;
        4'h3: e.cnd = zf;
        4'h4: e.cnd = !zf;
        4'h5: e.cnd = !(sf ^ of);
        4'h6: e.cnd = !(sf ^ of) && !zf;
        default: e.cnd = 1'b0;
      endcase
    end
    exp_q.push_back(e);
  endtask

  // Output monitor: a result is consumed on the next rising edge when valid and ready.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst && out_valid && out_ready) begin
      n_total++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output got valE=%h cnd=%b bad=%b with empty queue", valE, cnd, bad_instr);
      end else begin
        e = exp_q.pop_front();
        if ({valE, cnd, bad_instr} !== {e.vale, e.cnd, e.bad}) begin
          n_bad++;
          $display("FAIL result got valE=%h cnd=%b bad=%b want valE=%h cnd=%b bad=%b",
                   valE, cnd, bad_instr, e.vale, e.cnd, e.bad);
        end
      end
      last_vale = valE; last_cnd = cnd; last_bad = bad_instr;
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [3:0] ic, input logic [3:0] fn,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    int n = 0;
    in_valid = 1'b1; icode = ic; ifun = fn; valA = a; valB = b; valC = c;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk); out_ready = 1'b1; #1; n++;
    end
    if (!in_ready) begin
      n_total++; n_bad++;
      $display("FAIL send_timeout in_ready=%b want 1", in_ready);
    end else begin
      push_model(ic, fn, a, b, c);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      n_total++; n_bad++;
      $display("FAIL drain_timeout pending=%0d want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    icode = '0; ifun = '0; valA = '0; valB = '0; valC = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0; m_cc = 3'b100; exp_q.delete();
    #1;
    n_total++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_total++; if (cc !== 3'b100) begin n_bad++; $display("FAIL reset_cc got %b want 100", cc); end
    n_total++; if (valE !== 64'd0) begin n_bad++; $display("FAIL reset_valE got %h want 0", valE); end
    n_total++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_total++; if ({cnd, bad_instr} !== 2'b00) begin n_bad++; $display("FAIL reset_cnd_bad got %b want 00", {cnd, bad_instr}); end
    @(negedge clk);
  endtask

  task automatic test_sub_jl;
    send(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0);
    drain;
    n_total++; if (last_vale !== 64'h7FFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL sub_valE got %h want 7fffffffffffffff", last_vale); end
    n_total++; if (cc !== 3'b001) begin n_bad++; $display("FAIL sub_cc got %b want 001", cc); end
    send(4'h7, 4'h2, 64'd0, 64'd0, 64'd0);
    drain;
    n_total++; if (last_cnd !== 1'b1) begin n_bad++; $display("FAIL jl_cnd got %b want 1", last_cnd); end
  endtask

  task automatic test_add_cmov;
    send(4'h6, 4'h0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0);
    send(4'h2, 4'h1, 64'd77, 64'd3, 64'd0);
    drain;
    n_total++; if (cc !== 3'b100) begin n_bad++; $display("FAIL add_cc got %b want 100", cc); end
    n_total++; if ({last_vale, last_cnd} !== {64'd77, 1'b1}) begin n_bad++; $display("FAIL cmovle got valE=%h cnd=%b want 4d 1", last_vale, last_cnd); end
  endtask

  task automatic test_stack;
    send(4'hA, 4'h0, 64'd0, 64'h100, 64'd0);
    drain;
    n_total++; if (last_vale !== 64'hF8) begin n_bad++; $display("FAIL push_valE got %h want f8", last_vale); end
    send(4'hB, 4'h0, 64'd0, 64'hF8, 64'd0);
    drain;
    n_total++; if (last_vale !== 64'h100) begin n_bad++; $display("FAIL pop_valE got %h want 100", last_vale); end
    n_total++; if (cc !== 3'b100) begin n_bad++; $display("FAIL stack_cc got %b want 100", cc); end
  endtask

  task automatic test_random;
    logic [63:0] a, b;
    for (int i = 0; i < 60; i++) begin
      a = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = 64'd0 - a;
        default: b = {$urandom, $urandom};
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)), a, b, {$urandom, $urandom});
    end
    drain;
    n_total++; if (cc !== m_cc) begin n_bad++; $display("FAIL random_cc got %b want %b", cc, m_cc); end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    send(4'h6, 4'h3, 64'hF0, 64'h0F, 64'd0);
    in_valid = 1'b1; icode = 4'h3; ifun = 4'h0; valA = '0; valB = '0; valC = 64'h1234;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if ({in_ready, out_valid, valE} !== {1'b0, 1'b1, 64'hFF}) begin
        n_bad++;
        $display("FAIL hold got in_ready=%b out_valid=%b valE=%h want 0 1 ff", in_ready, out_valid, valE);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    push_model(4'h3, 4'h0, 64'd0, 64'd0, 64'h1234);
    @(negedge clk);
    send(4'h5, 4'h0, 64'd0, 64'h10, 64'h20);
    drain;
    n_total++; if (last_vale !== 64'h30) begin n_bad++; $display("FAIL b2b_last got %h want 30", last_vale); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    send(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0);
    #1;
    n_total++; if ({out_valid, cc} !== {1'b1, 3'b001}) begin n_bad++; $display("FAIL pre_reset got out_valid=%b cc=%b want 1 001", out_valid, cc); end
    rst = 1'b1;
    #1;
    n_total++; if ({out_valid, cc, valE} !== {1'b0, 3'b100, 64'd0}) begin n_bad++; $display("FAIL mid_reset got out_valid=%b cc=%b valE=%h want 0 100 0", out_valid, cc, valE); end
    exp_q.delete(); m_cc = 3'b100;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    send(4'hC, 4'h0, 64'd1, 64'd2, 64'd3);
    drain;
    n_total++; if ({last_bad, last_vale, last_cnd} !== {1'b1, 64'd0, 1'b0}) begin n_bad++; $display("FAIL bad_icode got bad=%b valE=%h cnd=%b want 1 0 0", last_bad, last_vale, last_cnd); end
    n_total++; if (cc !== 3'b100) begin n_bad++; $display("FAIL bad_icode_cc got %b want 100", cc); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    last_vale = '0; last_cnd = 1'b0; last_bad = 1'b0;
    test_reset;
    test_sub_jl;
    test_add_cmov;
    test_stack;
    test_random;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end
endmodule
